frame_sequencer: RTL
====================

# frame_sequencer

Frame-level controller between the geometry engine, the rasterizer and the frame/Z-buffer memories in `fpga_top`. On a start request it:
- clears the back framebuffer to 12'h000 and the Z-buffer to 8'hFF;
- kicks the geometry engine;
- watches the vertex FIFO and the rasterizer until the frame has drained, or a watchdog expires;
- swaps front/back buffers on the next vsync.

It also owns the animation frame index, advanced by `increment_frame`. It muxes the single memory write port between its own clear engine and the rasterizer.

## Interface
Parameters:
- PIXELS, 76800, number of framebuffer/Z-buffer entries (320x240).
- ADDR_W, 17, memory address width.
- TIMEOUT_CYCLES, 25000, render watchdog (250 us at 100 MHz).
- FRAME_W, 4, frame index width (16 frames, wraps).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_start  in  1  level input; rising edge requests a frame.
- i_increment_frame  in  1  level input; rising edge advances the frame index.
- i_vsync  in  1  one-cycle pulse from the display timing block.
- i_geo_done  in  1  one-cycle pulse from the geometry engine when its last vertex has been pushed.
- i_fifo_empty  in  1  vertex FIFO empty flag.
- i_rast_busy  in  1  rasterizer `o_busy`.
- i_rast_fb_addr / i_rast_fb_we / i_rast_fb_pixel  in  ADDR_W/1/12  rasterizer framebuffer write.
- i_rast_zb_w_addr / i_rast_zb_we / i_rast_zb_w_data  in  ADDR_W/1/8  rasterizer Z write.
- o_fb_addr / o_fb_we / o_fb_pixel  out  ADDR_W/1/12  muxed framebuffer write.
- o_zb_w_addr / o_zb_we / o_zb_w_data  out  ADDR_W/1/8  muxed Z write.
- o_geo_start  out  1  one-cycle start pulse to the geometry engine.
- o_frame_idx  out  FRAME_W  current animation frame.
- o_fb_sel  out  1  selects the back buffer; the display reads !o_fb_sel.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  sticky; set when the watchdog fires, cleared on the next accepted start.
- o_frame_done  out  1  one-cycle pulse at the buffer swap.

## Operation
- Reset value of every output is 0. All counters and rising-edge history registers also reset to 0.
- The state machine has six states: IDLE, CLEAR, KICK, RENDER, DRAIN, WAIT_VSYNC.
- IDLE:
  - A rising edge of i_increment_frame sets o_frame_idx to o_frame_idx+1, mod 2^FRAME_W.
  - A rising edge of i_start clears o_timeout and the geo_done latch, zeroes the clear counter, and moves to CLEAR.
  - If both edges occur in the same cycle, the increment is applied and the start is accepted.
- Edges of i_start and i_increment_frame outside IDLE are discarded, not queued.
- CLEAR:
  - The counter walks 0..PIXELS-1, one address per cycle.
  - Each cycle drives fb_we=1 with pixel 12'h000 and zb_we=1 with data 8'hFF, both at the counter address.
  - After address PIXELS-1 the state moves to KICK.
  - Rasterizer write inputs are ignored in this state.
- KICK: asserts o_geo_start for exactly one cycle, zeroes the watchdog, and moves to RENDER.
- RENDER:
  - The rasterizer write inputs pass through to the memory outputs.
  - A geo_done latch is set by i_geo_done.
  - When the latch is set and !i_rast_busy and i_fifo_empty, the state moves to DRAIN.
- DRAIN: passthrough continues. If the drain condition holds again this cycle, the state moves to WAIT_VSYNC; if not, it returns to RENDER. This bridges the one-cycle FIFO-to-assembler gap.
- Watchdog:
  - Increments every cycle in RENDER and DRAIN, saturating.
  - On reaching TIMEOUT_CYCLES-1 it sets o_timeout and forces WAIT_VSYNC. This takes priority over the drain transition.
  - A frame with zero triangles therefore completes through the drain path, not the timeout.
- WAIT_VSYNC: write enables are 0. On i_vsync, o_fb_sel toggles, o_frame_done pulses, and the state moves to IDLE. A vsync pulse arriving before this state is entered is ignored.
- Address arithmetic is unsigned ADDR_W bits. The clear counter never exceeds PIXELS-1.
- Reset mid-operation:
  - Asynchronous: all state returns to IDLE and the write enables drop immediately.
  - A partially cleared buffer is left as-is.
  - o_fb_sel returns to 0.

## Timing
- All outputs are registered; each memory output lags its source by 1 cycle.
- i_start rising edge at cycle N: state is CLEAR at N+1, and the first clear write (addr 0) appears on the outputs at N+2. The last clear write (addr PIXELS-1) appears at N+PIXELS+1.
- o_geo_start is high at cycle N+PIXELS+2.
- A rasterizer write presented at cycle M, while the state is RENDER or DRAIN at M, appears on the outputs at M+1.
- Drain condition first true at cycle D while in RENDER: state is DRAIN at D+1, and WAIT_VSYNC at D+2 if the condition also holds at D+1.
- i_vsync at cycle V while in WAIT_VSYNC: o_fb_sel toggles and o_frame_done=1 at V+1, and the state is IDLE at V+1.
- o_busy reflects the registered state, with no extra latency.

## Test plan
- Reset, PIXELS=16: i_start edge -> 16 consecutive writes, addr 0..15, fb data 000 and zb data FF, then one o_geo_start pulse exactly 18 cycles after the edge.
- Three i_increment_frame edges in IDLE, then 14 more -> o_frame_idx reads 3, then wraps to 1. An increment edge during CLEAR leaves the index unchanged.
- In RENDER, rasterizer writes addr 5 pixel ABC and Z addr 5 data 12 -> outputs show the same values one cycle later. The same inputs during CLEAR never reach the outputs.
- i_geo_done with busy=0 and empty=1 for 2 cycles, then i_vsync -> o_fb_sel 0->1, one-cycle o_frame_done, o_timeout=0, o_busy=0.
- TIMEOUT_CYCLES=50, i_rast_busy held high -> WAIT_VSYNC reached 50 cycles after KICK, o_timeout=1 until the next start. A second start clears it.
- rst_n pulled low mid-CLEAR at addr 7 -> all outputs 0 asynchronously. After release, a new start restarts the clear from addr 0.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame-level controller: clears the back buffers, kicks the geometry engine, waits for the
// render to drain (or the watchdog), then swaps buffers on vsync. Also owns the frame index.
module frame_sequencer #(
    parameter int unsigned PIXELS         = 76800,
    parameter int unsigned ADDR_W         = 17,
    parameter int unsigned TIMEOUT_CYCLES = 25000,
    parameter int unsigned FRAME_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_increment_frame,
    input  logic               i_vsync,
    input  logic               i_geo_done,
    input  logic               i_fifo_empty,
    input  logic               i_rast_busy,
    input  logic [ADDR_W-1:0]  i_rast_fb_addr,
    input  logic               i_rast_fb_we,
    input  logic [11:0]        i_rast_fb_pixel,
    input  logic [ADDR_W-1:0]  i_rast_zb_w_addr,
    input  logic               i_rast_zb_we,
    input  logic [7:0]         i_rast_zb_w_data,
    output logic [ADDR_W-1:0]  o_fb_addr,
    output logic               o_fb_we,
    output logic [11:0]        o_fb_pixel,
    output logic [ADDR_W-1:0]  o_zb_w_addr,
    output logic               o_zb_we,
    output logic [7:0]         o_zb_w_data,
    output logic               o_geo_start,
    output logic [FRAME_W-1:0] o_frame_idx,
    output logic               o_fb_sel,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_frame_done
);

    localparam int unsigned       WdW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ClrLast = ADDR_W'(PIXELS - 1);
    localparam logic [WdW-1:0]    WdLast  = WdW'(TIMEOUT_CYCLES - 1);
    localparam logic [WdW-1:0]    WdMax   = '1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StKick,
        StRender,
        StDrain,
        StWaitVsync
    } state_e;

    state_e state_q, state_d;

    logic               start_prev_q, incr_prev_q;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [WdW-1:0]     wd_q, wd_d;
    logic               geo_done_q, geo_done_d;
    logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
    logic               fb_sel_q, fb_sel_d;
    logic               timeout_q, timeout_d;
    logic               frame_done_q, frame_done_d;
    logic               geo_start_q, geo_start_d;
    logic               busy_q, busy_d;
    logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    logic               fb_we_q, fb_we_d;
    logic [11:0]        fb_pixel_q, fb_pixel_d;
    logic [ADDR_W-1:0]  zb_addr_q, zb_addr_d;
    logic               zb_we_q, zb_we_d;
    logic [7:0]         zb_data_q, zb_data_d;

    logic            start_edge, incr_edge, clr_last, drain_cond, wd_fire;
    logic [WdW-1:0]  wd_inc;

    assign start_edge = i_start & ~start_prev_q;
    assign incr_edge  = i_increment_frame & ~incr_prev_q;
    assign clr_last   = (clr_cnt_q == ClrLast);
    assign drain_cond = geo_done_q & ~i_rast_busy & i_fifo_empty;
    assign wd_inc     = (wd_q == WdMax) ? wd_q : wd_q + WdW'(1);
    // Fires on the cycle the watchdog steps onto its last count.
    assign wd_fire    = (wd_inc == WdLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (start_edge) state_d = StClear;
            StClear:     if (clr_last) state_d = StKick;
            StKick:      state_d = StRender;
            StRender: begin
                if (wd_fire)         state_d = StWaitVsync;
                else if (drain_cond) state_d = StDrain;
            end
            // A second qualifying cycle bridges the FIFO-to-assembler gap.
            StDrain: begin
                if (wd_fire || drain_cond) state_d = StWaitVsync;
                else                       state_d = StRender;
            end
            StWaitVsync: if (i_vsync) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        clr_cnt_d    = clr_cnt_q;
        wd_d         = wd_q;
        geo_done_d   = geo_done_q;
        frame_idx_d  = frame_idx_q;
        fb_sel_d     = fb_sel_q;
        timeout_d    = timeout_q;
        frame_done_d = 1'b0;
        geo_start_d  = 1'b0;
        busy_d       = (state_d != StIdle);
        fb_addr_d    = '0;
        fb_we_d      = 1'b0;
        fb_pixel_d   = '0;
        zb_addr_d    = '0;
        zb_we_d      = 1'b0;
        zb_data_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (incr_edge) frame_idx_d = frame_idx_q + FRAME_W'(1);
                if (start_edge) begin
                    timeout_d  = 1'b0;
                    geo_done_d = 1'b0;
                    clr_cnt_d  = '0;
                end
            end
            StClear: begin
                fb_addr_d  = clr_cnt_q;
                fb_we_d    = 1'b1;
                fb_pixel_d = 12'h000;
                zb_addr_d  = clr_cnt_q;
                zb_we_d    = 1'b1;
                zb_data_d  = 8'hFF;
                if (!clr_last) clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
            StKick: begin
                geo_start_d = 1'b1;
                wd_d        = '0;
            end
            StRender, StDrain: begin
                fb_addr_d  = i_rast_fb_addr;
                fb_we_d    = i_rast_fb_we;
                fb_pixel_d = i_rast_fb_pixel;
                zb_addr_d  = i_rast_zb_w_addr;
                zb_we_d    = i_rast_zb_we;
                zb_data_d  = i_rast_zb_w_data;
                wd_d       = wd_inc;
                if (i_geo_done) geo_done_d = 1'b1;
                if (wd_fire)    timeout_d  = 1'b1;
            end
            StWaitVsync: begin
                if (i_vsync) begin
                    fb_sel_d     = ~fb_sel_q;
                    frame_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_q <= 1'b0;
            incr_prev_q  <= 1'b0;
            clr_cnt_q    <= '0;
            wd_q         <= '0;
            geo_done_q   <= 1'b0;
            frame_idx_q  <= '0;
            fb_sel_q     <= 1'b0;
            timeout_q    <= 1'b0;
            frame_done_q <= 1'b0;
            geo_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            fb_addr_q    <= '0;
            fb_we_q      <= 1'b0;
            fb_pixel_q   <= '0;
            zb_addr_q    <= '0;
            zb_we_q      <= 1'b0;
            zb_data_q    <= '0;
        end else begin
            start_prev_q <= i_start;
            incr_prev_q  <= i_increment_frame;
            clr_cnt_q    <= clr_cnt_d;
            wd_q         <= wd_d;
            geo_done_q   <= geo_done_d;
            frame_idx_q  <= frame_idx_d;
            fb_sel_q     <= fb_sel_d;
            timeout_q    <= timeout_d;
            frame_done_q <= frame_done_d;
            geo_start_q  <= geo_start_d;
            busy_q       <= busy_d;
            fb_addr_q    <= fb_addr_d;
            fb_we_q      <= fb_we_d;
            fb_pixel_q   <= fb_pixel_d;
            zb_addr_q    <= zb_addr_d;
            zb_we_q      <= zb_we_d;
            zb_data_q    <= zb_data_d;
        end
    end

    assign o_fb_addr    = fb_addr_q;
    assign o_fb_we      = fb_we_q;
    assign o_fb_pixel   = fb_pixel_q;
    assign o_zb_w_addr  = zb_addr_q;
    assign o_zb_we      = zb_we_q;
    assign o_zb_w_data  = zb_data_q;
    assign o_geo_start  = geo_start_q;
    assign o_frame_idx  = frame_idx_q;
    assign o_fb_sel     = fb_sel_q;
    assign o_busy       = busy_q;
    assign o_timeout    = timeout_q;
    assign o_frame_done = frame_done_q;

endmodule
